seq_rx_monitor: RTL and testbench

- Receiver/checker for the 3-bit walking-code sequence produced by our sequence generator: 0 -> 3 -> 6 -> 1 -> 5 -> 7, then 7 held.
- Sits on the far side of a valid-qualified symbol link.
- Tracks the expected next code and flags the first mismatch.
- Counts complete sequences and regenerates the generator's z1 flag from received data so both ends can be cross-checked by the property checker.

---
 rtl/seq_pkg.sv | 66 ++++++
 rtl/seq_sat_counter.sv | 22 ++
 rtl/seq_rx_monitor.sv | 160 ++++++++++++++++
 tb/tb_seq_rx_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the walking-code sequence generator and receiver.
// The code walks 0 -> 3 -> 6 -> 1 -> 5 -> 7 and then holds at 7.
package seq_pkg;

    localparam logic [2:0] SEQ_C0 = 3'd0;
    localparam logic [2:0] SEQ_C1 = 3'd3;
    localparam logic [2:0] SEQ_C2 = 3'd6;
    localparam logic [2:0] SEQ_C3 = 3'd1;
    localparam logic [2:0] SEQ_C4 = 3'd5;
    localparam logic [2:0] SEQ_C5 = 3'd7;

    // Sn means "the last accepted code was n".
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        S0   = 3'd1,
        S3   = 3'd2,
        S6   = 3'd3,
        S1   = 3'd4,
        S5   = 3'd5,
        DONE = 3'd6,
        ERR  = 3'd7
    } seq_state_t;

    // Code the link should carry next, given where we are in the sequence.
    // Both ends use this so they cannot disagree on the walk order.
    function automatic logic [2:0] next_expected(input seq_state_t st);
        case (st)
            HUNT:    return SEQ_C0;
            S0:      return SEQ_C1;
            S3:      return SEQ_C2;
            S6:      return SEQ_C3;
            S1:      return SEQ_C4;
            S5:      return SEQ_C5;
            DONE:    return SEQ_C5;
            default: return SEQ_C0;
        endcase
    endfunction

    // Successor state after the expected code has been seen.
    function automatic seq_state_t next_on_match(input seq_state_t st);
        case (st)
            HUNT:    return S0;
            S0:      return S3;
            S3:      return S6;
            S6:      return S1;
            S1:      return S5;
            S5:      return DONE;
            DONE:    return DONE;
            default: return HUNT;
        endcase
    endfunction

    // Sequence index of the last accepted code for a given state.
    function automatic logic [2:0] state_pos(input seq_state_t st);
        case (st)
            S0:      return 3'd0;
            S3:      return 3'd1;
            S6:      return 3'd2;
            S1:      return 3'd3;
            S5:      return 3'd4;
            DONE:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at MAX.
module seq_sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority over increment; increment is dropped once at MAX.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_rx_monitor.sv
// Receiver/checker for the walking-code sequence. Frames on the first 0,
// tracks the expected next code, latches the first mismatch, counts complete
// sequences and regenerates the generator's z1 flag from received data.
module seq_rx_monitor #(
    parameter int CNT_W    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [2:0]       sym,
    input  logic             err_clr,
    output logic             z1,
    output logic [2:0]       pos,
    output logic             in_seq,
    output logic             seq_done,
    output logic             err,
    output logic [2:0]       err_sym,
    output logic [2:0]       err_exp,
    output logic             hold_ovf,
    output logic [CNT_W-1:0] seq_cnt
);

    import seq_pkg::*;

    localparam int                HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    seq_state_t        state, state_nxt;
    logic [2:0]        exp_sym;
    logic [HOLD_W-1:0] hold_cnt;

    logic       accept, mismatch, done_hit, hold_hit, restart;
    logic       z1_nxt, in_seq_nxt, err_nxt, hold_ovf_nxt;
    logic [2:0] pos_nxt, err_sym_nxt, err_exp_nxt;

    assign exp_sym = next_expected(state);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: only valid symbols move the FSM, except err_clr in ERR.
    always_comb begin
        state_nxt = state;
        if (state == ERR) begin
            if (err_clr) begin
                state_nxt = HUNT;
            end
        end else if (sym_valid) begin
            case (state)
                HUNT: begin
                    if (sym == SEQ_C0) state_nxt = S0;
                end
                S0, S3, S6, S1, S5: begin
                    state_nxt = (sym == exp_sym) ? next_on_match(state) : ERR;
                end
                DONE: begin
                    if (sym == SEQ_C5)      state_nxt = DONE;
                    else if (sym == SEQ_C0) state_nxt = S0;
                    else                    state_nxt = ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        accept = 1'b0;
        if (sym_valid) begin
            case (state)
                HUNT:    accept = (sym == SEQ_C0);
                DONE:    accept = (sym == SEQ_C5) || (sym == SEQ_C0);
                ERR:     accept = 1'b0;
                default: accept = (sym == exp_sym);
            endcase
        end

        // Unframed symbols in HUNT are never errors; ERR ignores everything.
        mismatch = sym_valid && (state != HUNT) && (state != ERR) && !accept;
        done_hit = sym_valid && (state == S5) && (sym == SEQ_C5);
        hold_hit = sym_valid && (state == DONE) && (sym == SEQ_C5);
        restart  = sym_valid && (state == DONE) && (sym == SEQ_C0);

        z1_nxt     = accept ? (sym[2] & sym[0]) : z1;
        pos_nxt    = accept ? state_pos(state_nxt) : pos;
        in_seq_nxt = (state_nxt == S0) || (state_nxt == S3) || (state_nxt == S6) ||
                     (state_nxt == S1) || (state_nxt == S5);

        err_nxt     = err;
        err_sym_nxt = err_sym;
        err_exp_nxt = err_exp;
        if (mismatch) begin
            // Only reachable outside ERR, so the first capture is never overwritten.
            err_nxt     = 1'b1;
            err_sym_nxt = sym;
            err_exp_nxt = exp_sym;
        end else if ((state == ERR) && err_clr) begin
            err_nxt     = 1'b0;
            err_sym_nxt = 3'd0;
            err_exp_nxt = 3'd0;
        end

        // err_clr clears the overflow flag in any state and wins over a new set.
        hold_ovf_nxt = hold_ovf;
        if (err_clr) begin
            hold_ovf_nxt = 1'b0;
        end else if (hold_hit && (hold_cnt == HOLD_LIM)) begin
            hold_ovf_nxt = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            z1       <= 1'b0;
            pos      <= 3'd0;
            in_seq   <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_sym  <= 3'd0;
            err_exp  <= 3'd0;
            hold_ovf <= 1'b0;
        end else begin
            z1       <= z1_nxt;
            pos      <= pos_nxt;
            in_seq   <= in_seq_nxt;
            seq_done <= done_hit;
            err      <= err_nxt;
            err_sym  <= err_sym_nxt;
            err_exp  <= err_exp_nxt;
            hold_ovf <= hold_ovf_nxt;
        end
    end

    // Completed-sequence counter, cleared only by reset.
    seq_sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (done_hit),
        .count (seq_cnt)
    );

    // Held-7 run length in DONE; restarts on every entry to DONE or on a restart 0.
    seq_sat_counter #(.W(HOLD_W), .MAX(HOLD_LIM)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (done_hit || restart),
        .inc   (hold_hit),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_seq_rx_monitor.sv
// Scoreboard bench: the driver feeds both DUTs (8-bit and 2-bit counters) and
// pushes the reference model's expected outputs; the monitor pops and compares
// one entry per clock.
module tb_seq_rx_monitor;

    localparam int HOLD_MAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, sym_valid, err_clr;
    logic [2:0] sym;

    logic       a_z1, a_in_seq, a_seq_done, a_err, a_hold_ovf;
    logic [2:0] a_pos, a_err_sym, a_err_exp;
    logic [7:0] a_seq_cnt;
    logic       b_z1, b_in_seq, b_seq_done, b_err, b_hold_ovf;
    logic [2:0] b_pos, b_err_sym, b_err_exp;
    logic [1:0] b_seq_cnt;

    seq_rx_monitor #(.CNT_W(8), .HOLD_MAX(HOLD_MAX)) dut_a (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .err_clr(err_clr),
        .z1(a_z1), .pos(a_pos), .in_seq(a_in_seq), .seq_done(a_seq_done), .err(a_err),
        .err_sym(a_err_sym), .err_exp(a_err_exp), .hold_ovf(a_hold_ovf), .seq_cnt(a_seq_cnt)
    );

    seq_rx_monitor #(.CNT_W(2), .HOLD_MAX(HOLD_MAX)) dut_b (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .err_clr(err_clr),
        .z1(b_z1), .pos(b_pos), .in_seq(b_in_seq), .seq_done(b_seq_done), .err(b_err),
        .err_sym(b_err_sym), .err_exp(b_err_exp), .hold_ovf(b_hold_ovf), .seq_cnt(b_seq_cnt)
    );

    typedef struct {
        bit z1; int pos; bit in_seq; bit done; bit err;
        int esym; int eexp; bit hovf; int cnt;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: position in the code list plus a few flags.
    int codes[6] = '{0, 3, 6, 1, 5, 7};
    bit m_framed, m_err, m_z1, m_done, m_hovf;
    int m_idx, m_hold, m_cnt, m_esym, m_eexp, m_pos;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit v, input int s, input bit clr, input bit rst);
        exp_t e;
        m_done = 1'b0;
        if (rst) begin
            m_framed = 0; m_err = 0; m_z1 = 0; m_hovf = 0;
            m_idx = 0; m_hold = 0; m_cnt = 0; m_esym = 0; m_eexp = 0; m_pos = 0;
        end else if (m_err) begin
            if (clr) begin
                m_err = 0; m_esym = 0; m_eexp = 0; m_hovf = 0; m_framed = 0;
            end
        end else begin
            if (v) begin
                if (!m_framed) begin
                    if (s == 0) begin
                        m_framed = 1; m_idx = 0; m_pos = 0; m_z1 = 0;
                    end
                end else if (m_idx == 5) begin
                    if (s == 7) begin
                        if (m_hold >= HOLD_MAX) m_hovf = 1;
                        else m_hold++;
                        m_pos = 5; m_z1 = 1;
                    end else if (s == 0) begin
                        m_idx = 0; m_hold = 0; m_pos = 0; m_z1 = 0;
                    end else begin
                        m_err = 1; m_esym = s; m_eexp = 7;
                    end
                end else if (s == codes[m_idx+1]) begin
                    m_idx++;
                    m_pos = m_idx;
                    m_z1 = (s == 5) || (s == 7);
                    if (m_idx == 5) begin
                        m_done = 1; m_cnt++; m_hold = 0;
                    end
                end else begin
                    m_err = 1; m_esym = s; m_eexp = codes[m_idx+1];
                end
            end
            if (clr) m_hovf = 0;
        end
        e.z1 = m_z1; e.pos = m_pos; e.done = m_done; e.err = m_err;
        e.in_seq = m_framed && !m_err && (m_idx < 5);
        e.esym = m_esym; e.eexp = m_eexp; e.hovf = m_hovf; e.cnt = m_cnt;
        expq.push_back(e);
    endtask

    task automatic step(input bit v, input logic [2:0] s, input bit clr, input bit rst);
        @(negedge clk);
        sym_valid = v; sym = s; err_clr = clr; reset = rst;
        model_step(v, int'(s), clr, rst);
    endtask

    task automatic send(input logic [2:0] s);
        step(1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic seq_full();
        for (int i = 0; i < 6; i++) send(3'(codes[i]));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] want();
        if (!m_framed || m_err) return 3'd0;
        if (m_idx == 5) return ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd7;
        return 3'(codes[m_idx+1]);
    endfunction

    exp_t mon_e;

    // Monitor: one expected entry per clock, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("z1",       a_z1,       mon_e.z1);
            chk("pos",      a_pos,      mon_e.pos);
            chk("in_seq",   a_in_seq,   mon_e.in_seq);
            chk("seq_done", a_seq_done, mon_e.done);
            chk("err",      a_err,      mon_e.err);
            chk("err_sym",  a_err_sym,  mon_e.esym);
            chk("err_exp",  a_err_exp,  mon_e.eexp);
            chk("hold_ovf", a_hold_ovf, mon_e.hovf);
            chk("seq_cnt8", a_seq_cnt,  (mon_e.cnt > 255) ? 255 : mon_e.cnt);
            chk("b_seq_cnt2", b_seq_cnt, (mon_e.cnt > 3) ? 3 : mon_e.cnt);
            chk("b_seq_done", b_seq_done, mon_e.done);
            chk("b_err",    b_err,      mon_e.err);
            chk("b_pos",    b_pos,      mon_e.pos);
            chk("b_hold_ovf", b_hold_ovf, mon_e.hovf);
        end
    end

    initial begin
        reset = 1'b1; sym_valid = 1'b0; sym = 3'd0; err_clr = 1'b0;

        // Reset state.
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        settle();
        chk("rst_err", a_err, 0); chk("rst_pos", a_pos, 0); chk("rst_cnt", a_seq_cnt, 0);

        // Full sequence then idle.
        seq_full(); idle(); idle();
        settle();
        chk("p1_cnt", a_seq_cnt, 1); chk("p1_pos", a_pos, 5); chk("p1_z1", a_z1, 1);

        // Early mismatch, ignored symbol, clear.
        step(0, 0, 0, 1);
        send(0); send(3); send(4);
        settle();
        chk("p2_err", a_err, 1); chk("p2_esym", a_err_sym, 4); chk("p2_eexp", a_err_exp, 6);
        send(6);
        settle();
        chk("p2_pos_hold", a_pos, 1);
        step(0, 0, 1, 0);
        settle();
        chk("p2_clr", a_err, 0);
        send(3);

        // Framing noise and idle gaps.
        step(0, 0, 0, 1);
        send(5); send(6); send(7);
        send(0); send(3); send(6); idle(); idle(); idle(); send(1); send(5); send(7);
        settle();
        chk("p3_cnt", a_seq_cnt, 1); chk("p3_err", a_err, 0);

        // Hold overflow and restart.
        step(0, 0, 0, 1);
        seq_full();
        for (int i = 0; i < HOLD_MAX; i++) send(7);
        settle();
        chk("p4_no_ovf", a_hold_ovf, 0);
        send(7);
        settle();
        chk("p4_ovf", a_hold_ovf, 1);
        send(0); send(3);
        settle();
        chk("p4_pos", a_pos, 1); chk("p4_err", a_err, 0);

        // Reset mid-sequence.
        send(0); send(3); send(6);
        step(0, 0, 0, 1);
        send(3);
        settle();
        chk("p5_pos", a_pos, 0); chk("p5_in_seq", a_in_seq, 0); chk("p5_ovf", a_hold_ovf, 0);

        // Counter saturation on the 2-bit instance.
        step(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) seq_full();
        idle();
        settle();
        chk("p6_cnt2", b_seq_cnt, 3); chk("p6_cnt8", a_seq_cnt, 5);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            bit         rv, rclr, rrst;
            logic [2:0] rs;
            rrst = ($urandom_range(0, 199) == 0);
            rv   = ($urandom_range(0, 99) < 80);
            rclr = ($urandom_range(0, 99) < 4);
            rs   = ($urandom_range(0, 99) < 80) ? want() : 3'($urandom_range(0, 7));
            step(rv, rs, rclr, rrst);
        end
        idle();

        repeat (3) @(posedge clk);
        #2;
        chk("drain", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
